// File: rtl/cpu_mmu_cache_seq_if.sv
// Signal bundle between the CPU access port, the MMU tag comparator,
// the cache RAM strobes and the system bus, as seen by the sequencer.
interface cpu_mmu_cache_seq_if #(
    parameter int CNT_W = 16
) ();
    // CPU access request
    logic             REQ;
    logic             WRITE;
    logic [13:0]      PPN_23_10;
    // Comparator and cache control
    logic             CON_n;
    logic             HIT0_n;
    logic             HIT1_n;
    logic             FMISS;
    logic             TAG_WE;
    logic [13:0]      TAG_DATA;
    logic             DATA_WE;
    // System bus handshake
    logic             BUS_REQ;
    logic             BUS_GNT;
    logic             BUS_ACK;
    logic             BUS_ERR;
    // Access status
    logic             RDY;
    logic             ERR;
    logic             HIT;
    logic             BUSY;
    logic [CNT_W-1:0] MISS_CNT;

    // Sequencer side
    modport slave (
        input  REQ, WRITE, PPN_23_10, CON_n, HIT0_n, HIT1_n,
        input  BUS_GNT, BUS_ACK, BUS_ERR,
        output FMISS, BUS_REQ, TAG_WE, TAG_DATA, DATA_WE,
        output RDY, ERR, HIT, BUSY, MISS_CNT
    );

    // CPU / comparator / bus side
    modport master (
        output REQ, WRITE, PPN_23_10, CON_n, HIT0_n, HIT1_n,
        output BUS_GNT, BUS_ACK, BUS_ERR,
        input  FMISS, BUS_REQ, TAG_WE, TAG_DATA, DATA_WE,
        input  RDY, ERR, HIT, BUSY, MISS_CNT
    );
endinterface

// File: rtl/cpu_mmu_cache_seq.sv
// Cache access sequencer sitting behind the MMU tag comparator.
// Decides hit/miss for each CPU access, runs the bus cycle on misses and
// on every write (write-through), and refills tag/data after a read miss.
module cpu_mmu_cache_seq #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    cpu_mmu_cache_seq_if.slave    bus
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_BREQ,
        S_WAIT,
        S_FILL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [13:0]        tag_q, tag_d;
    logic               write_q, write_d;
    logic               hit_flag_q, hit_flag_d;
    logic               fill_flag_q, fill_flag_d;
    logic               err_flag_q, err_flag_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               fmiss_q, fmiss_d;

    logic               hit_now;
    logic               bus_req;
    logic               tag_we;
    logic               data_we;
    logic               rdy;

    // Comparator result is only meaningful with the cache enabled.
    assign hit_now = !bus.HIT0_n && !bus.HIT1_n && !bus.CON_n;

    // Next-state, flag updates and per-state strobes.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        write_d     = write_q;
        hit_flag_d  = hit_flag_q;
        fill_flag_d = fill_flag_q;
        err_flag_d  = err_flag_q;
        tmo_cnt_d   = tmo_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fmiss_d     = 1'b0;
        bus_req     = 1'b0;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        rdy         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    tag_d       = bus.PPN_23_10;
                    write_d     = bus.WRITE;
                    hit_flag_d  = 1'b0;
                    fill_flag_d = 1'b0;
                    err_flag_d  = 1'b0;
                    state_d     = S_CMP;
                end
            end

            S_CMP: begin
                if (hit_now) begin
                    hit_flag_d = 1'b1;
                end
                if (!write_q && hit_now) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BREQ;
                    // Only a cached read miss refills and is counted.
                    if (!write_q && !bus.CON_n) begin
                        fill_flag_d = 1'b1;
                        if (miss_cnt_q != {CNT_W{1'b1}}) begin
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        end
                    end
                end
                // Write hit updates the cached copy; the bus cycle follows.
                if (write_q && hit_now) begin
                    data_we = 1'b1;
                end
            end

            S_BREQ: begin
                bus_req = 1'b1;
                if (bus.BUS_GNT) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                bus_req   = 1'b1;
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // An ack in the same cycle as an error or timeout wins.
                if (bus.BUS_ACK) begin
                    state_d = fill_flag_q ? S_FILL : S_DONE;
                end else if (bus.BUS_ERR || (tmo_cnt_q == TMO_W'(TIMEOUT - 1))) begin
                    err_flag_d = 1'b1;
                    state_d    = S_DONE;
                end
            end

            S_FILL: begin
                tag_we  = 1'b1;
                data_we = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                rdy     = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any bus cycle.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q     <= S_IDLE;
            tag_q       <= '0;
            write_q     <= 1'b0;
            hit_flag_q  <= 1'b0;
            fill_flag_q <= 1'b0;
            err_flag_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            fmiss_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            write_q     <= write_d;
            hit_flag_q  <= hit_flag_d;
            fill_flag_q <= fill_flag_d;
            err_flag_q  <= err_flag_d;
            tmo_cnt_q   <= tmo_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            fmiss_q     <= fmiss_d;
        end
    end

    // Force-miss covers the tag write and the first cycle out of reset,
    // when tag RAM contents cannot be trusted.
    assign bus.FMISS    = fmiss_q || (state_q == S_FILL);
    assign bus.BUS_REQ  = bus_req;
    assign bus.TAG_WE   = tag_we;
    assign bus.TAG_DATA = tag_q;
    assign bus.DATA_WE  = data_we;
    assign bus.RDY      = rdy;
    assign bus.ERR      = rdy && err_flag_q;
    assign bus.HIT      = rdy && hit_flag_q;
    assign bus.BUSY     = (state_q != S_IDLE);
    assign bus.MISS_CNT = miss_cnt_q;

endmodule

// File: tb/tb_cpu_mmu_cache_seq.sv
// Directed bench for the cache access sequencer. A second instance with a
// 4-bit miss counter sees identical stimulus to exercise saturation.
module tb_cpu_mmu_cache_seq;

    logic sysclk;
    logic sysreset;

    int n_cmp;
    int n_bad;
    int exp_miss;

    cpu_mmu_cache_seq_if #(.CNT_W(16)) bif ();
    cpu_mmu_cache_seq_if #(.CNT_W(4))  bif4 ();

    cpu_mmu_cache_seq #(.TIMEOUT(64), .CNT_W(16)) u_dut (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .bus      (bif)
    );

    cpu_mmu_cache_seq #(.TIMEOUT(64), .CNT_W(4)) u_dut4 (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .bus      (bif4)
    );

    assign bif4.REQ       = bif.REQ;
    assign bif4.WRITE     = bif.WRITE;
    assign bif4.PPN_23_10 = bif.PPN_23_10;
    assign bif4.CON_n     = bif.CON_n;
    assign bif4.HIT0_n    = bif.HIT0_n;
    assign bif4.HIT1_n    = bif.HIT1_n;
    assign bif4.BUS_GNT   = bif.BUS_GNT;
    assign bif4.BUS_ACK   = bif.BUS_ACK;
    assign bif4.BUS_ERR   = bif.BUS_ERR;

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic look();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Cached read miss with an immediate grant and a first-cycle ack.
    // Starts and ends in an IDLE cycle.
    task automatic read_miss(input logic [13:0] ppn);
        bif.REQ = 1'b1; bif.WRITE = 1'b0; bif.PPN_23_10 = ppn;
        bif.HIT0_n = 1'b1; bif.HIT1_n = 1'b1; bif.CON_n = 1'b0;
        cyc(); bif.REQ = 1'b0;                         // CMP
        cyc(); bif.BUS_GNT = 1'b1;                     // BREQ
        cyc(); bif.BUS_GNT = 1'b0; bif.BUS_ACK = 1'b1; // WAIT0
        cyc(); bif.BUS_ACK = 1'b0; look();             // FILL
        chk("loop_fill_tag_data", 32'(bif.TAG_DATA), 32'(ppn));
        chk("loop_fill_tag_we", 32'(bif.TAG_WE), 32'd1);
        cyc(); look();                                 // DONE
        chk("loop_done_rdy", 32'(bif.RDY), 32'd1);
        cyc();                                         // IDLE
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_miss = 0;
        sysreset = 1'b1;
        bif.REQ = 1'b0; bif.WRITE = 1'b0; bif.PPN_23_10 = 14'h0;
        bif.CON_n = 1'b0; bif.HIT0_n = 1'b1; bif.HIT1_n = 1'b1;
        bif.BUS_GNT = 1'b0; bif.BUS_ACK = 1'b0; bif.BUS_ERR = 1'b0;

        // ---------------- reset state ----------------
        cyc(); cyc(); look();
        chk("rst_fmiss", 32'(bif.FMISS), 32'd1);
        chk("rst_busy", 32'(bif.BUSY), 32'd0);
        chk("rst_bus_req", 32'(bif.BUS_REQ), 32'd0);
        chk("rst_rdy", 32'(bif.RDY), 32'd0);
        chk("rst_tag_data", 32'(bif.TAG_DATA), 32'h0);
        chk("rst_miss_cnt", 32'(bif.MISS_CNT), 32'h0);
        sysreset = 1'b0;
        cyc(); look();
        chk("rst_fmiss_drops", 32'(bif.FMISS), 32'd0);
        $display("txn reset done");

        // ---------------- read hit ----------------
        bif.REQ = 1'b1; bif.WRITE = 1'b0; bif.PPN_23_10 = 14'h1A3C;
        bif.HIT0_n = 1'b0; bif.HIT1_n = 1'b0; bif.CON_n = 1'b0;
        look();
        chk("rh_idle_busy", 32'(bif.BUSY), 32'd0);
        cyc(); bif.REQ = 1'b0; look();                 // CMP
        chk("rh_cmp_busy", 32'(bif.BUSY), 32'd1);
        chk("rh_cmp_bus_req", 32'(bif.BUS_REQ), 32'd0);
        chk("rh_cmp_tag_data", 32'(bif.TAG_DATA), 32'h1A3C);
        chk("rh_cmp_data_we", 32'(bif.DATA_WE), 32'd0);
        cyc(); look();                                 // DONE: third cycle counting REQ
        chk("rh_done_rdy", 32'(bif.RDY), 32'd1);
        chk("rh_done_hit", 32'(bif.HIT), 32'd1);
        chk("rh_done_err", 32'(bif.ERR), 32'd0);
        chk("rh_done_bus_req", 32'(bif.BUS_REQ), 32'd0);
        cyc(); look();                                 // IDLE
        chk("rh_idle_rdy", 32'(bif.RDY), 32'd0);
        chk("rh_idle_hit", 32'(bif.HIT), 32'd0);
        chk("rh_miss_cnt", 32'(bif.MISS_CNT), 32'h0);
        $display("txn read-hit ppn=1a3c");

        // ---------------- read miss with fill ----------------
        bif.REQ = 1'b1; bif.PPN_23_10 = 14'h2001; bif.HIT0_n = 1'b0; bif.HIT1_n = 1'b1;
        cyc(); bif.REQ = 1'b0; look();                 // CMP
        chk("rm_cmp_bus_req", 32'(bif.BUS_REQ), 32'd0);
        cyc(); look();                                 // BREQ 1
        chk("rm_breq_bus_req", 32'(bif.BUS_REQ), 32'd1);
        chk("rm_breq_miss_cnt", 32'(bif.MISS_CNT), 32'h1);
        exp_miss = 1;
        cyc(); bif.BUS_GNT = 1'b1; look();             // BREQ 2, grant arrives
        chk("rm_breq2_bus_req", 32'(bif.BUS_REQ), 32'd1);
        cyc(); bif.BUS_GNT = 1'b0; look();             // WAIT0
        chk("rm_wait_bus_req", 32'(bif.BUS_REQ), 32'd1);
        chk("rm_wait_tag_we", 32'(bif.TAG_WE), 32'd0);
        cyc();                                         // WAIT1
        cyc(); bif.BUS_ACK = 1'b1;                     // WAIT2, ack
        cyc(); bif.BUS_ACK = 1'b0; look();             // FILL
        chk("rm_fill_tag_we", 32'(bif.TAG_WE), 32'd1);
        chk("rm_fill_data_we", 32'(bif.DATA_WE), 32'd1);
        chk("rm_fill_fmiss", 32'(bif.FMISS), 32'd1);
        chk("rm_fill_tag_data", 32'(bif.TAG_DATA), 32'h2001);
        chk("rm_fill_bus_req", 32'(bif.BUS_REQ), 32'd0);
        cyc(); look();                                 // DONE
        chk("rm_done_rdy", 32'(bif.RDY), 32'd1);
        chk("rm_done_hit", 32'(bif.HIT), 32'd0);
        chk("rm_done_err", 32'(bif.ERR), 32'd0);
        chk("rm_done_tag_we", 32'(bif.TAG_WE), 32'd0);
        chk("rm_done_fmiss", 32'(bif.FMISS), 32'd0);
        cyc();
        $display("txn read-miss ppn=2001 miss_cnt=%0d", bif.MISS_CNT);

        // ---------------- write hit (write-through) ----------------
        bif.REQ = 1'b1; bif.WRITE = 1'b1; bif.PPN_23_10 = 14'h0155;
        bif.HIT0_n = 1'b0; bif.HIT1_n = 1'b0;
        cyc(); bif.REQ = 1'b0; bif.WRITE = 1'b0; look(); // CMP
        chk("wh_cmp_data_we", 32'(bif.DATA_WE), 32'd1);
        chk("wh_cmp_tag_we", 32'(bif.TAG_WE), 32'd0);
        cyc(); bif.BUS_GNT = 1'b1; look();             // BREQ
        chk("wh_breq_data_we", 32'(bif.DATA_WE), 32'd0);
        chk("wh_breq_bus_req", 32'(bif.BUS_REQ), 32'd1);
        cyc(); bif.BUS_GNT = 1'b0; bif.BUS_ACK = 1'b1; look(); // WAIT0
        chk("wh_wait_bus_req", 32'(bif.BUS_REQ), 32'd1);
        cyc(); bif.BUS_ACK = 1'b0; look();             // DONE, no fill
        chk("wh_done_rdy", 32'(bif.RDY), 32'd1);
        chk("wh_done_hit", 32'(bif.HIT), 32'd1);
        chk("wh_done_tag_we", 32'(bif.TAG_WE), 32'd0);
        chk("wh_miss_cnt", 32'(bif.MISS_CNT), 32'h1);
        cyc();
        $display("txn write-hit ppn=0155");

        // ---------------- write miss, bus error pulse ----------------
        bif.REQ = 1'b1; bif.WRITE = 1'b1; bif.PPN_23_10 = 14'h0777; bif.HIT1_n = 1'b1;
        cyc(); bif.REQ = 1'b0; bif.WRITE = 1'b0; look(); // CMP
        chk("be_cmp_data_we", 32'(bif.DATA_WE), 32'd0);
        cyc(); bif.BUS_GNT = 1'b1;                     // BREQ
        cyc(); bif.BUS_GNT = 1'b0;                     // WAIT0
        cyc();                                         // WAIT1
        cyc(); bif.BUS_ERR = 1'b1;                     // WAIT2
        cyc(); bif.BUS_ERR = 1'b0; look();             // DONE
        chk("be_done_rdy", 32'(bif.RDY), 32'd1);
        chk("be_done_err", 32'(bif.ERR), 32'd1);
        cyc();
        $display("txn write bus-error ppn=0777");

        // ---------------- timeout ----------------
        bif.REQ = 1'b1; bif.WRITE = 1'b1; bif.PPN_23_10 = 14'h0888;
        cyc(); bif.REQ = 1'b0; bif.WRITE = 1'b0;       // CMP
        cyc(); bif.BUS_GNT = 1'b1;                     // BREQ
        cyc(); bif.BUS_GNT = 1'b0;                     // WAIT cycle 0
        repeat (63) cyc();                             // WAIT cycle 63
        look();
        chk("to_wait63_rdy", 32'(bif.RDY), 32'd0);
        chk("to_wait63_bus_req", 32'(bif.BUS_REQ), 32'd1);
        cyc(); look();                                 // 64 cycles after WAIT entry
        chk("to_done_rdy", 32'(bif.RDY), 32'd1);
        chk("to_done_err", 32'(bif.ERR), 32'd1);
        chk("to_done_hit", 32'(bif.HIT), 32'd0);
        cyc();
        $display("txn write timeout ppn=0888");

        // ---------------- ack colliding with error and timeout ----------------
        bif.REQ = 1'b1; bif.WRITE = 1'b1; bif.PPN_23_10 = 14'h0999;
        cyc(); bif.REQ = 1'b0; bif.WRITE = 1'b0;       // CMP
        cyc(); bif.BUS_GNT = 1'b1;                     // BREQ
        cyc(); bif.BUS_GNT = 1'b0;                     // WAIT cycle 0
        repeat (63) cyc();                             // WAIT cycle 63
        bif.BUS_ACK = 1'b1; bif.BUS_ERR = 1'b1;
        cyc(); bif.BUS_ACK = 1'b0; bif.BUS_ERR = 1'b0; look(); // DONE
        chk("col_done_rdy", 32'(bif.RDY), 32'd1);
        chk("col_done_err", 32'(bif.ERR), 32'd0);
        cyc();
        $display("txn write ack/err collision ppn=0999");

        // ---------------- bypass (cache off) ----------------
        bif.REQ = 1'b1; bif.WRITE = 1'b0; bif.PPN_23_10 = 14'h0AAA;
        bif.HIT0_n = 1'b0; bif.HIT1_n = 1'b0; bif.CON_n = 1'b1;
        cyc(); bif.REQ = 1'b0; look();                 // CMP
        chk("bp_cmp_data_we", 32'(bif.DATA_WE), 32'd0);
        cyc(); bif.BUS_GNT = 1'b1; look();             // BREQ
        chk("bp_breq_bus_req", 32'(bif.BUS_REQ), 32'd1);
        cyc(); bif.BUS_GNT = 1'b0; bif.BUS_ACK = 1'b1; // WAIT0
        cyc(); bif.BUS_ACK = 1'b0; look();             // DONE, no FILL
        chk("bp_done_rdy", 32'(bif.RDY), 32'd1);
        chk("bp_done_hit", 32'(bif.HIT), 32'd0);
        chk("bp_done_tag_we", 32'(bif.TAG_WE), 32'd0);
        chk("bp_miss_cnt", 32'(bif.MISS_CNT), 32'h1);
        cyc();
        bif.CON_n = 1'b0;
        $display("txn bypass read ppn=0aaa");

        // ---------------- 17 read misses: saturation of the 4-bit counter ----------------
        for (int i = 0; i < 17; i++) begin
            read_miss(14'(14'h0100 + i));
            exp_miss++;
            look();
            chk("sat_miss_cnt16", 32'(bif.MISS_CNT), 32'(exp_miss));
            chk("sat_miss_cnt4", 32'(bif4.MISS_CNT), 32'(sat4(exp_miss)));
            $display("txn read-miss #%0d miss_cnt=%0d miss_cnt4=%0d", i, bif.MISS_CNT, bif4.MISS_CNT);
        end
        chk("sat_final4", 32'(bif4.MISS_CNT), 32'hF);
        chk("sat_final16", 32'(bif.MISS_CNT), 32'h12);

        // ---------------- reset in the middle of WAIT ----------------
        bif.REQ = 1'b1; bif.WRITE = 1'b0; bif.PPN_23_10 = 14'h1555;
        bif.HIT0_n = 1'b1; bif.HIT1_n = 1'b1;
        cyc(); bif.REQ = 1'b0;                         // CMP
        cyc(); bif.BUS_GNT = 1'b1;                     // BREQ
        cyc(); bif.BUS_GNT = 1'b0;                     // WAIT0
        cyc(); sysreset = 1'b1;                        // WAIT1
        cyc(); sysreset = 1'b0; look();                // IDLE after reset
        chk("mr_busy", 32'(bif.BUSY), 32'd0);
        chk("mr_bus_req", 32'(bif.BUS_REQ), 32'd0);
        chk("mr_fmiss", 32'(bif.FMISS), 32'd1);
        chk("mr_tag_data", 32'(bif.TAG_DATA), 32'h0);
        chk("mr_miss_cnt", 32'(bif.MISS_CNT), 32'h0);
        chk("mr_miss_cnt4", 32'(bif4.MISS_CNT), 32'h0);
        chk("mr_rdy", 32'(bif.RDY), 32'd0);
        $display("txn reset mid-wait");
        // Clean access immediately afterwards.
        cyc();
        bif.REQ = 1'b1; bif.PPN_23_10 = 14'h3FFF; bif.HIT0_n = 1'b0; bif.HIT1_n = 1'b0;
        look();
        chk("mr_fmiss_clear", 32'(bif.FMISS), 32'd0);
        cyc(); bif.REQ = 1'b0; look();                 // CMP
        chk("mr_cmp_busy", 32'(bif.BUSY), 32'd1);
        chk("mr_cmp_tag_data", 32'(bif.TAG_DATA), 32'h3FFF);
        cyc(); look();                                 // DONE
        chk("mr_done_rdy", 32'(bif.RDY), 32'd1);
        chk("mr_done_hit", 32'(bif.HIT), 32'd1);
        cyc();
        $display("txn read-hit after reset ppn=3fff");

        // ---------------- REQ held high across DONE ----------------
        bif.REQ = 1'b1; bif.PPN_23_10 = 14'h0ABC;
        cyc();                                         // CMP, REQ still high
        cyc(); look();                                 // DONE
        chk("hold_done_rdy", 32'(bif.RDY), 32'd1);
        cyc(); look();                                 // IDLE despite REQ
        chk("hold_idle_busy", 32'(bif.BUSY), 32'd0);
        chk("hold_idle_rdy", 32'(bif.RDY), 32'd0);
        cyc(); bif.REQ = 1'b0; look();                 // CMP of second access
        chk("hold_cmp_busy", 32'(bif.BUSY), 32'd1);
        cyc(); look();                                 // DONE
        chk("hold_done2_rdy", 32'(bif.RDY), 32'd1);
        chk("hold_done2_hit", 32'(bif.HIT), 32'd1);
        cyc();
        $display("txn back-to-back read-hit ppn=0abc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
